instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 17 +
 rtl/instruction_fetch_if.sv | 31 +++
 rtl/instruction_fetch_mem.sv | 25 ++
 rtl/instruction_fetch.sv | 80 ++++++++
 tb/tb_instruction_fetch.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode constants: special instruction encodings, PC step and fetch-stage state.
package instruction_fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } fetch_state_e;

  function automatic logic is_halt(input logic [31:0] word);
    return (word == HALT_INSTR);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: pipeline control from hazard/ID, program-load port and IF/ID outputs.
interface instruction_fetch_if #(
  parameter int IMEM_DEPTH = 256
);
  localparam int AW = $clog2(IMEM_DEPTH);

  logic          i_enable;
  logic          i_stall;
  logic          i_jump;
  logic [31:0]   i_jump_address;
  logic          i_imem_we;
  logic [AW-1:0] i_imem_waddr;
  logic [31:0]   i_imem_wdata;
  logic [31:0]   o_instruction;
  logic [31:0]   o_pc;
  logic          o_halt;
  logic [31:0]   o_pc_next;

  modport master (
    output i_enable, i_stall, i_jump, i_jump_address,
    output i_imem_we, i_imem_waddr, i_imem_wdata,
    input  o_instruction, o_pc, o_halt, o_pc_next
  );

  modport slave (
    input  i_enable, i_stall, i_jump, i_jump_address,
    input  i_imem_we, i_imem_waddr, i_imem_wdata,
    output o_instruction, o_pc, o_halt, o_pc_next
  );

endinterface

// File: rtl/instruction_fetch_mem.sv
// Instruction memory: one synchronous write port, one combinational read port, no reset.
module instruction_memory #(
  parameter int IMEM_DEPTH = 256,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [IMEM_DEPTH];

  // Contents survive reset so a program loaded while the core is held stays put.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC selection and IF/ID register, with sticky HALT freeze.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  instruction_fetch_if.slave   io_bus
);

  localparam int AW = $clog2(IMEM_DEPTH);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_if_pc;
  logic [31:0]  w_pc_next;
  logic [31:0]  w_instr_next;
  logic [31:0]  w_if_pc_next;
  logic [31:0]  w_fetch_word;
  logic [AW-1:0] w_rd_idx;

  // Byte address bits [1:0] are ignored; bits above the index wrap.
  assign w_rd_idx = r_pc[AW+1:2];

  instruction_memory #(
    .IMEM_DEPTH (IMEM_DEPTH)
  ) u_imem (
    .i_clk   (i_clk),
    .i_we    (io_bus.i_imem_we),
    .i_waddr (io_bus.i_imem_waddr),
    .i_wdata (io_bus.i_imem_wdata),
    .i_raddr (w_rd_idx),
    .o_rdata (w_fetch_word)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_RUN;
      r_pc    <= PC_RESET;
      r_instr <= NOP_INSTR;
      r_if_pc <= 32'h0000_0000;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
      r_if_pc <= w_if_pc_next;
    end
  end

  // Priority: halted > disabled > stalled > jump > sequential; a jump flushes the wrong-path word.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    w_if_pc_next = r_if_pc;
    if (r_state == ST_RUN && io_bus.i_enable && !io_bus.i_stall) begin
      w_if_pc_next = r_pc;
      if (io_bus.i_jump) begin
        w_pc_next    = io_bus.i_jump_address;
        w_instr_next = NOP_INSTR;
      end else begin
        w_pc_next    = r_pc + PC_STEP;
        w_instr_next = w_fetch_word;
        if (is_halt(w_fetch_word)) begin
          w_state_next = ST_HALTED;
        end
      end
    end
  end

  assign io_bus.o_instruction = r_instr;
  assign io_bus.o_pc          = r_if_pc;
  assign io_bus.o_halt        = (r_state == ST_HALTED);
  assign io_bus.o_pc_next     = r_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with hand-computed expectations.
module tb_instruction_fetch;

  logic clk;
  logic resetN;
  int   checkCount;
  int   passCount;

  instruction_fetch_if #(.IMEM_DEPTH(256)) bus ();

  instruction_fetch #(
    .IMEM_DEPTH (256),
    .PC_RESET   (32'h0000_0000)
  ) dut (
    .i_clk   (clk),
    .i_reset (resetN),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic st, input logic jp, input logic [31:0] addr);
    bus.i_enable       = en;
    bus.i_stall        = st;
    bus.i_jump         = jp;
    bus.i_jump_address = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [31:0] pcNext, input logic [31:0] ifPc,
                            input logic [31:0] instr, input logic halt);
    checkOutput({tag, "_pcnext"}, bus.o_pc_next, pcNext);
    checkOutput({tag, "_pc"}, bus.o_pc, ifPc);
    checkOutput({tag, "_instr"}, bus.o_instruction, instr);
    checkOutput({tag, "_halt"}, {31'b0, bus.o_halt}, {31'b0, halt});
  endtask

  task automatic writeMem(input logic [7:0] idx, input logic [31:0] data);
    bus.i_imem_we    = 1'b1;
    bus.i_imem_waddr = idx;
    bus.i_imem_wdata = data;
    tick();
    bus.i_imem_we    = 1'b0;
  endtask

  // Asserts reset between edges so the checks see the asynchronous clear, then holds it one edge.
  task automatic doReset(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    resetN = 1'b0;
    #1;
    checkState(tag, 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    resetN     = 1'b0;
    bus.i_imem_we    = 1'b0;
    bus.i_imem_waddr = '0;
    bus.i_imem_wdata = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    #1;
    checkState("por", 32'h0, 32'h0, 32'h0, 1'b0);

    // Program load while held in reset
    for (int i = 0; i < 256; i++) begin
      writeMem(i[7:0], 32'h1000_0000 + i);
    end
    writeMem(8'd0, 32'h11);
    writeMem(8'd1, 32'h22);
    writeMem(8'd2, 32'h33);
    writeMem(8'd3, 32'h44);
    checkState("loadrst", 32'h0, 32'h0, 32'h0, 1'b0);
    resetN = 1'b1;

    // Sequential fetch
    tick(); checkState("seq0", 32'h4, 32'h0, 32'h11, 1'b0);
    tick(); checkState("seq1", 32'h8, 32'h4, 32'h22, 1'b0);
    tick(); checkState("seq2", 32'hC, 32'h8, 32'h33, 1'b0);
    tick(); checkState("seq3", 32'h10, 32'hC, 32'h44, 1'b0);

    // Jump flushes to NOP, no delay slot
    doReset("rstjmp");
    resetN = 1'b1;
    tick(); tick();
    checkState("prejmp", 32'h8, 32'h4, 32'h22, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h20);
    tick(); checkState("jmp", 32'h20, 32'h8, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); checkState("postjmp", 32'h24, 32'h20, 32'h1000_0008, 1'b0);

    // Stall beats jump, jump taken once stall drops
    doReset("rststl");
    resetN = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
    for (int k = 0; k < 2; k++) begin
      tick(); checkState("stall", 32'h4, 32'h0, 32'h11, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h40);
    tick(); checkState("stalljmp", 32'h40, 32'h4, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

    // Disabled pipeline while the current word is rewritten
    doReset("rsten");
    resetN = 1'b1;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h80);
    bus.i_imem_we    = 1'b1;
    bus.i_imem_waddr = 8'd1;
    bus.i_imem_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 5; k++) begin
      tick(); checkState("disabled", 32'h4, 32'h0, 32'h11, 1'b0);
    end
    bus.i_imem_we = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); checkState("reen", 32'h8, 32'h4, 32'hDEAD_BEEF, 1'b0);
    // Same-edge write to the fetched word returns old data
    bus.i_imem_we    = 1'b1;
    bus.i_imem_waddr = 8'd2;
    bus.i_imem_wdata = 32'hCAFE_F00D;
    tick(); checkState("rdold", 32'hC, 32'h8, 32'h33, 1'b0);
    bus.i_imem_we = 1'b0;

    // HALT: suppressed by jump and stall, then sticky
    doReset("rsthlt");
    writeMem(8'd1, 32'h22);
    writeMem(8'd2, 32'h33);
    writeMem(8'd3, 32'hFFFF_FFFF);
    resetN = 1'b1;
    tick(); tick(); tick();
    checkState("prehlt", 32'hC, 32'h8, 32'h33, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0);
    tick(); checkState("hltjmp", 32'h0, 32'hC, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); tick(); tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick(); checkState("hltstall", 32'hC, 32'h8, 32'h33, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); checkState("halt", 32'h10, 32'hC, 32'hFFFF_FFFF, 1'b1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(k % 3 != 0, k % 4 == 1, k % 2 == 0, 32'h100 + k * 4);
      tick(); checkState("frozen", 32'h10, 32'hC, 32'hFFFF_FFFF, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    resetN = 1'b0;
    #1;
    checkState("hltrst", 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    writeMem(8'd3, 32'h44);
    resetN = 1'b1;
    tick(); checkState("afterhlt", 32'h4, 32'h0, 32'h11, 1'b0);

    // Index wrap at the top of memory and 32-bit PC wrap
    doReset("rstwrap");
    resetN = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h3FC);
    tick(); checkState("jmp3fc", 32'h3FC, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); checkState("at3fc", 32'h400, 32'h3FC, 32'h1000_00FF, 1'b0);
    tick(); checkState("at400", 32'h404, 32'h400, 32'h11, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick(); checkState("jmptop", 32'hFFFF_FFFC, 32'h404, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    tick(); checkState("pcwrap", 32'h0, 32'hFFFF_FFFC, 32'h1000_00FF, 1'b0);
    tick(); checkState("wrapfetch", 32'h4, 32'h0, 32'h11, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
